reg_write_arbiter: RTL
======================

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 Parameter N, default 4: number of requesters, 2..8.
REQ-002 Parameter W, default 8: data width of the shared register write port.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 req  input  N  per-requester write request; held high until its ack.
REQ-006 data  input  N*W  requester i data in bits [i*W +: W]; stable while req[i] is high.
REQ-007 ack  output  N  one-hot; one-cycle pulse to the requester whose write is being issued.
REQ-008 reg_d  output  W  data to the shared register's d input.
REQ-009 reg_en  output  1  write enable to the shared register's en input.
REQ-010 busy  output  1  high whenever state is not IDLE.

Function
REQ-011 The FSM SHALL have states IDLE, WRITE, and LOCKED (LOCKED only with REG_ARB_LOCK_EN).
- IDLE: if any req bit is high, select the winner, latch data[winner] into reg_d, and go to WRITE; otherwise stay.
- WRITE: for exactly one cycle, reg_en=1, ack[winner]=1, reg_d=latched data; then go to IDLE (or LOCKED, per REQ-021).
REQ-012 Latency SHALL be one cycle: with req sampled high at IDLE edge k, reg_en and ack are high during cycle k+1.
REQ-013 Peak throughput SHALL be one write per two cycles; back-to-back requests SHALL each pass through IDLE.
REQ-014 All outputs SHALL be registered; ack, reg_en, and busy SHALL be low in IDLE.
REQ-015 Arbitration SHALL be round-robin: search starts at pointer ptr and proceeds ptr, ptr+1, ... mod N; the first high req wins.
REQ-016 After each WRITE, ptr SHALL become (winner+1) mod N, wrapping from N-1 to 0.
REQ-017 Requesters SHALL deassert req on the edge ending their ack cycle, so a served request is never re-arbitrated; a req still high in IDLE SHALL be treated as a new request.
REQ-018 When all N requests rise in the same cycle, exactly one ack SHALL fire per WRITE, in ptr order.
REQ-019 req changes during WRITE SHALL NOT affect the ongoing write; reg_d SHALL hold its value outside WRITE.

Reset
REQ-020 Asserting rst at any time, including mid-WRITE, SHALL immediately force:
- state=IDLE
- ptr=0
- ack=0, reg_en=0, busy=0
- reg_d=0
No write SHALL be issued in the cycle after rst deasserts unless req was sampled in IDLE.

Configuration
REQ-021 With macro REG_ARB_LOCK_EN defined:
- Add input lock (N bits).
- If lock[winner] is high in WRITE, the FSM SHALL go to LOCKED instead of IDLE, and ptr SHALL NOT advance.
- LOCKED: only req[owner] is honoured, which goes to WRITE; other reqs are ignored.
- LOCKED: lock[owner] low SHALL return the FSM to IDLE with ptr=(owner+1) mod N.
- busy SHALL be high in LOCKED.
REQ-022 Without REG_ARB_LOCK_EN: no lock port and no LOCKED state; behaviour is exactly REQ-011..REQ-020.

Structure
REQ-023 Package reg_arb_pkg SHALL hold the state enumeration/encoding and the default N and W constants.
REQ-024 Sub-module rr_pick SHALL be purely combinational: inputs req and ptr, outputs one-hot winner and its index.
REQ-025 reg_write_arbiter SHALL contain the FSM, ptr, data latch, and output registers.

Verification
REQ-026 Single request: N=4, W=8, req=0010, data[1]=8'hA5 -> next cycle reg_en=1, reg_d=A5, ack=0010; ptr=2 afterwards.
REQ-027 All-request fairness: req=1111 held, each dropped after its ack -> acks in order 0001, 0010, 0100, 1000, each two cycles apart.
REQ-028 Wrap: ptr=3, req=1001 -> ack=1000 first, then ack=0001; ptr ends at 1.
REQ-029 Reset mid-write: rst pulsed during WRITE -> reg_en=0, ack=0, reg_d=00, busy=0 immediately; ptr=0.
REQ-030 Lock (REG_ARB_LOCK_EN): requester 2 wins with lock[2]=1 while req[0] is high -> requester 2 gets two consecutive writes, req[0] is ignored; lock[2]=0 -> IDLE, then ack=0001.

Source files
------------

// File: rtl/reg_arb_pkg.sv
// -----------------------------------------------------------------------------
// reg_arb_pkg
// Shared definitions for the round-robin register write arbiter.
//   REG_ARB_N / REG_ARB_W : default requester count and data width
//   arb_state_e           : FSM state encoding (LOCKED exists only when the
//                           REG_ARB_LOCK_EN macro is defined)
//   wrap_inc()            : (idx + 1) mod n without a divider
//   idx_width()           : bits needed to hold an index 0..n-1
// Optional feature macro: REG_ARB_LOCK_EN
// -----------------------------------------------------------------------------
package reg_arb_pkg;

   localparam int REG_ARB_N = 4;
   localparam int REG_ARB_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WRITE  = 2'd1
`ifdef REG_ARB_LOCK_EN
      ,
      ST_LOCKED = 2'd2
`endif
   } arb_state_e;

   function automatic int wrap_inc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/reg_write_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Purely combinational round-robin picker. Searches req starting at ptr and
// moving upward modulo N; the first set bit wins.
// Ports:
//   req       in  [N-1:0]   request vector
//   ptr       in  [PW-1:0]  index where the search starts (must be < N)
//   grant     out [N-1:0]   one-hot winner (all zero when nothing requested)
//   grant_idx out [PW-1:0]  binary index of the winner
//   valid     out           at least one request present
// Optional feature macro: REG_ARB_LOCK_EN (not used in this file)
// -----------------------------------------------------------------------------
module rr_pick
   import reg_arb_pkg::*;
#(
   parameter int N  = REG_ARB_N,
   parameter int PW = idx_width(REG_ARB_N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [PW-1:0] grant_idx,
   output logic          valid
);

   // cand[k] is the requester index examined at search offset k.
   logic [PW-1:0] cand [N];

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_cand
         // One extra bit so ptr + offset (< 2N) cannot overflow before wrapping.
         logic [PW:0] sum;
         assign sum = {1'b0, ptr} + (PW+1)'(gi);
         assign cand[gi] = (sum >= (PW+1)'(N)) ? PW'(sum - (PW+1)'(N)) : sum[PW-1:0];
      end
   endgenerate

   // Walk offsets from farthest to nearest so the nearest hit overwrites.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      valid     = 1'b0;
      for (int k = N - 1; k >= 0; k--) begin
         if (req[cand[k]]) begin
            grant           = '0;
            grant[cand[k]]  = 1'b1;
            grant_idx       = cand[k];
            valid           = 1'b1;
         end
      end
   end

endmodule

// File: rtl/reg_write_arbiter.sv
// -----------------------------------------------------------------------------
// reg_write_arbiter
// Round-robin arbiter that funnels N requesters onto one shared register
// write port. A request sampled in IDLE produces a single WRITE cycle on the
// next clock (reg_en + one-hot ack), after which the FSM returns to IDLE and
// the search pointer moves past the winner. All outputs are registered.
// Ports:
//   clk     in            clock
//   rst     in            asynchronous active-high reset
//   req     in  [N-1:0]   per-requester request, held until its ack
//   data    in  [N*W-1:0] requester i data in bits [i*W +: W]
//   lock    in  [N-1:0]   (REG_ARB_LOCK_EN only) keep ownership after a write
//   ack     out [N-1:0]   one-hot, one-cycle pulse to the requester served
//   reg_d   out [W-1:0]   data to the shared register (held outside WRITE)
//   reg_en  out           write enable to the shared register
//   busy    out           high whenever the FSM is not IDLE
// Optional feature macro: REG_ARB_LOCK_EN adds the lock port and the LOCKED
// state, in which only the owning requester may write again.
// -----------------------------------------------------------------------------
module reg_write_arbiter
   import reg_arb_pkg::*;
#(
   parameter int N = REG_ARB_N,
   parameter int W = REG_ARB_W
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   req,
   input  logic [N*W-1:0] data,
`ifdef REG_ARB_LOCK_EN
   input  logic [N-1:0]   lock,
`endif
   output logic [N-1:0]   ack,
   output logic [W-1:0]   reg_d,
   output logic           reg_en,
   output logic           busy
);

   localparam int PW = idx_width(N);

   arb_state_e    state_q,  state_d;
   logic [PW-1:0] ptr_q,    ptr_d;
   logic [PW-1:0] owner_q,  owner_d;
   logic [N-1:0]  ack_q,    ack_d;
   logic [W-1:0]  reg_d_q,  reg_d_d;
   logic          reg_en_q, reg_en_d;
   logic          busy_q,   busy_d;

   logic [N-1:0]  pick_grant;
   logic [PW-1:0] pick_idx;
   logic          pick_valid;
   logic [PW-1:0] owner_next;
   logic [W-1:0]  req_data [N];

   rr_pick #(
      .N  (N),
      .PW (PW)
   ) u_pick (
      .req       (req),
      .ptr       (ptr_q),
      .grant     (pick_grant),
      .grant_idx (pick_idx),
      .valid     (pick_valid)
   );

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_data
         assign req_data[gi] = data[gi*W +: W];
      end
   endgenerate

   // Pointer value once the current owner is released.
   assign owner_next = PW'(wrap_inc(int'(owner_q), N));

`ifdef REG_ARB_LOCK_EN
   logic [N-1:0] owner_onehot;
   assign owner_onehot = N'(1) << owner_q;
`endif

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      owner_d  = owner_q;
      ack_d    = '0;
      reg_en_d = 1'b0;
      reg_d_d  = reg_d_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_valid) begin
               state_d  = ST_WRITE;
               owner_d  = pick_idx;
               ack_d    = pick_grant;
               reg_en_d = 1'b1;
               reg_d_d  = req_data[pick_idx];
            end
         end
         ST_WRITE: begin
            // req is ignored here; the write in flight is already latched.
`ifdef REG_ARB_LOCK_EN
            if (lock[owner_q]) begin
               // Owner keeps the port; pointer stays put until release.
               state_d = ST_LOCKED;
            end else begin
               state_d = ST_IDLE;
               ptr_d   = owner_next;
            end
`else
            state_d = ST_IDLE;
            ptr_d   = owner_next;
`endif
         end
`ifdef REG_ARB_LOCK_EN
         ST_LOCKED: begin
            // Release takes priority over a further write from the owner.
            if (!lock[owner_q]) begin
               state_d = ST_IDLE;
               ptr_d   = owner_next;
            end else if (req[owner_q]) begin
               state_d  = ST_WRITE;
               ack_d    = owner_onehot;
               reg_en_d = 1'b1;
               reg_d_d  = req_data[owner_q];
            end
         end
`endif
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         ptr_q    <= '0;
         owner_q  <= '0;
         ack_q    <= '0;
         reg_d_q  <= '0;
         reg_en_q <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         owner_q  <= owner_d;
         ack_q    <= ack_d;
         reg_d_q  <= reg_d_d;
         reg_en_q <= reg_en_d;
         busy_q   <= busy_d;
      end
   end

   assign ack    = ack_q;
   assign reg_d  = reg_d_q;
   assign reg_en = reg_en_q;
   assign busy   = busy_q;

endmodule
